// File: rtl/status_ascii_encoder.sv
`default_nettype none
// ============================================================================
// Module   : status_ascii_encoder
// Purpose  : Snapshots an 8-bit status word and sends it to a byte-wide UART
//            transmitter as the six-byte ASCII line "S=HH\r\n" (uppercase
//            hex). A message is sent on request, or on a status change when
//            AUTO_SEND is set.
// Revision : 1.0 - initial release
// ============================================================================
module status_ascii_encoder #(
  parameter int         AUTO_SEND = 1,
  parameter logic [7:0] PREFIX    = 8'h53
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_status,
  input  logic       i_send_req,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] c_EQ       = 8'h3D;
  localparam logic [7:0] c_CR       = 8'h0D;
  localparam logic [7:0] c_LF       = 8'h0A;
  localparam logic [2:0] c_LAST_IDX = 3'd5;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  // Byte at position idx of the line for status value s.
  function automatic logic [7:0] f_byte(input logic [2:0] idx, input logic [7:0] s);
    case (idx)
      3'd0:    return PREFIX;
      3'd1:    return c_EQ;
      3'd2:    return f_hex(s[7:4]);
      3'd3:    return f_hex(s[3:0]);
      3'd4:    return c_CR;
      default: return c_LF;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [7:0] r_snap, w_snap_nxt;
  logic [7:0] r_last_sent, w_last_sent_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic       r_pend, w_pend_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_tx_start, w_tx_start_nxt;
  logic       r_busy, w_busy_nxt;

  logic       w_auto_hit;
  logic       w_trigger;
  logic [2:0] w_idx_inc;

  // The last-sent compare makes the newest status win after a message, so
  // intermediate values seen mid-message are simply skipped.
  assign w_auto_hit = (AUTO_SEND != 0) && (i_status != r_last_sent);
  assign w_trigger  = i_send_req | r_pend | w_auto_hit;
  assign w_idx_inc  = r_idx + 3'd1;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    w_state_nxt     = r_state;
    w_snap_nxt      = r_snap;
    w_last_sent_nxt = r_last_sent;
    w_idx_nxt       = r_idx;
    w_pend_nxt      = r_pend;
    w_tx_data_nxt   = r_tx_data;
    w_tx_start_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_snap_nxt      = i_status;
          w_last_sent_nxt = i_status;
          w_idx_nxt       = 3'd0;
          w_tx_data_nxt   = f_byte(3'd0, i_status);
          w_pend_nxt      = 1'b0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_START;
        end
      end
      ST_START: begin
        if (i_send_req) begin
          w_pend_nxt = 1'b1;
        end
        if (!i_tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_send_req) begin
          w_pend_nxt = 1'b1;
        end
        if (i_tx_done) begin
          if (r_idx == c_LAST_IDX) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_tx_data_nxt = f_byte(w_idx_inc, r_snap);
            w_state_nxt   = ST_START;
          end
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_snap      <= 8'h00;
      r_last_sent <= 8'h00;
      r_idx       <= 3'd0;
      r_pend      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_snap      <= w_snap_nxt;
      r_last_sent <= w_last_sent_nxt;
      r_idx       <= w_idx_nxt;
      r_pend      <= w_pend_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_status_ascii_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_ascii_encoder
// Purpose  : Bench for status_ascii_encoder. Instance 0 is request-only
//            (AUTO_SEND=0), instance 1 sends on status change (AUTO_SEND=1).
//            Each has a simple transmitter model that pulses done a set
//            number of cycles after each start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_ascii_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] status     [2];
  logic       req        [2];
  logic       force_busy [2];
  logic       inj_done   [2];
  logic       mbusy      [2];
  logic       done       [2];
  int         dly        [2];

  logic [7:0] dat0, dat1;
  logic       stt0, stt1, bsy0, bsy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int         cnt        [2];
  logic [7:0] held       [2];
  int         nbytes     [2];
  logic       prev_start [2];
  logic       chk_after  [2];

  status_ascii_encoder #(.AUTO_SEND(0), .PREFIX(8'h53)) dut_r (
    .clk        (clk),
    .reset      (rst_n),
    .i_status   (status[0]),
    .i_send_req (req[0]),
    .i_tx_busy  (mbusy[0] | force_busy[0]),
    .i_tx_done  (done[0] | inj_done[0]),
    .o_tx_data  (dat0),
    .o_tx_start (stt0),
    .o_busy     (bsy0)
  );

  status_ascii_encoder #(.AUTO_SEND(1), .PREFIX(8'h53)) dut_a (
    .clk        (clk),
    .reset      (rst_n),
    .i_status   (status[1]),
    .i_send_req (req[1]),
    .i_tx_busy  (mbusy[1] | force_busy[1]),
    .i_tx_done  (done[1] | inj_done[1]),
    .o_tx_data  (dat1),
    .o_tx_start (stt1),
    .o_busy     (bsy1)
  );

  typedef struct {
    logic [7:0] st;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference line built straight from the ASCII rules.
  function automatic logic [7:0] hx(input logic [3:0] n);
    int v;
    v = (n < 4'd10) ? 48 + int'(n) : 65 + int'(n) - 10;
    return 8'(v);
  endfunction

  function automatic logic [47:0] model_msg(input logic [7:0] s);
    return {8'h53, 8'h3D, hx(s[7:4]), hx(s[3:0]), 8'h0D, 8'h0A};
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Transmitter model and byte monitor for both instances.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d;
      logic       s, b;
      d = (k == 0) ? dat0 : dat1;
      s = (k == 0) ? stt0 : stt1;
      b = (k == 0) ? bsy0 : bsy1;
      if (!rst_n) begin
        cnt[k] = 0; mbusy[k] = 1'b0; done[k] = 1'b0; nbytes[k] = 0;
        prev_start[k] = 1'b0; chk_after[k] = 1'b0;
      end else begin
        if (chk_after[k]) begin
          chk_after[k] = 1'b0;
          chk(b == ((nbytes[k] % 6) != 0), "busy_after_done", 64'(b), 64'((nbytes[k] % 6) != 0));
        end
        done[k] = 1'b0;
        if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            done[k]      = 1'b1;
            mbusy[k]     = 1'b0;
            chk_after[k] = 1'b1;
            chk(d == held[k], "data_stable", 64'(d), 64'(held[k]));
          end
        end
        if (s) begin
          chk(!prev_start[k], "no_back_to_back_start", 64'(prev_start[k]), 64'(0));
          chk(b, "busy_at_start", 64'(b), 64'(1));
          if (k == 0) q0.push_back(d); else q1.push_back(d);
          held[k]  = d;
          cnt[k]   = dly[k];
          mbusy[k] = 1'b1;
          nbytes[k]++;
        end
        prev_start[k] = s;
      end
    end
  end

  task automatic wait_idle(input int k, input string name);
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 4; c++) begin
      @(negedge clk);
      if (((k == 0) ? bsy0 : bsy1) == 1'b0) quiet++; else quiet = 0;
    end
    if (quiet < 4) chk(1'b0, {name, "_idle_timeout"}, 64'(quiet), 64'(4));
  endtask

  task automatic wait_bytes(input int k, input int n, input string name);
    for (int c = 0; c < 1000 && qsize(k) < n; c++) @(negedge clk);
    if (qsize(k) < n) chk(1'b0, {name, "_bytes_timeout"}, 64'(qsize(k)), 64'(n));
  endtask

  task automatic expect_msg(input int k, input string name, input logic [47:0] exp);
    logic [47:0] got = '0;
    if (qsize(k) < 6) begin
      chk(1'b0, {name, "_short"}, 64'(qsize(k)), 64'(6));
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (k == 0) got = {got[39:0], q0.pop_front()};
        else        got = {got[39:0], q1.pop_front()};
      end
      chk(got == exp, name, 64'(got), 64'(exp));
    end
  endtask

  task automatic expect_empty(input int k, input string name);
    chk(qsize(k) == 0, {name, "_extra_bytes"}, 64'(qsize(k)), 64'(0));
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  task automatic pulse_req(input int k);
    req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
  endtask

  initial begin
    vec_t        vecs [6];
    logic [7:0]  s;
    logic [7:0]  cur;
    logic        bad;

    vecs[0] = '{8'h09, 8'h30, 8'h39};
    vecs[1] = '{8'h0A, 8'h30, 8'h41};
    vecs[2] = '{8'hF0, 8'h46, 8'h30};
    vecs[3] = '{8'hFF, 8'h46, 8'h46};
    vecs[4] = '{8'hA5, 8'h41, 8'h35};
    vecs[5] = '{8'h00, 8'h30, 8'h30};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      status[k] = 8'h00; req[k] = 1'b0; force_busy[k] = 1'b0;
      inj_done[k] = 1'b0; dly[k] = 10;
    end
    repeat (3) @(negedge clk);
    chk({dat0, stt0, bsy0} == 10'h0, "reset_state_r", 64'({dat0, stt0, bsy0}), 64'(0));
    chk({dat1, stt1, bsy1} == 10'h0, "reset_state_a", 64'({dat1, stt1, bsy1}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Request-only instance: a status change alone sends nothing.
    status[0] = 8'hA5;
    repeat (20) @(negedge clk);
    chk(bsy0 == 1'b0, "no_auto_when_disabled_busy", 64'(bsy0), 64'(0));
    expect_empty(0, "no_auto_when_disabled");

    pulse_req(0);
    wait_idle(0, "req_send");
    expect_msg(0, "req_send", 48'h533D41350D0A);
    expect_empty(0, "req_send");
    chk(bsy0 == 1'b0, "req_send_busy_low", 64'(bsy0), 64'(0));

    // Table-driven hex boundaries.
    for (int i = 0; i < 6; i++) begin
      status[0] = vecs[i].st;
      pulse_req(0);
      wait_idle(0, "hex_vec");
      expect_msg(0, "hex_vec", {8'h53, 8'h3D, vecs[i].hi, vecs[i].lo, 8'h0D, 8'h0A});
      expect_empty(0, "hex_vec");
    end

    // Randomized requests against the reference line.
    for (int i = 0; i < 8; i++) begin
      dly[0] = int'($urandom_range(1, 12));
      s = 8'($urandom);
      status[0] = s;
      pulse_req(0);
      wait_idle(0, "rand_req");
      expect_msg(0, "rand_req", model_msg(s));
      expect_empty(0, "rand_req");
    end

    // Auto send on change, then silence while the status holds.
    status[1] = 8'h3F;
    @(negedge clk);
    wait_idle(1, "auto_send");
    expect_msg(1, "auto_send", 48'h533D33460D0A);
    repeat (50) @(negedge clk);
    expect_empty(1, "auto_hold");

    // Transmitter busy backpressure while in START.
    force_busy[1] = 1'b1;
    status[1] = 8'h11;
    @(negedge clk);
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stt1 || dat1 != 8'h53 || !bsy1) bad = 1'b1;
    end
    chk(!bad, "backpressure_hold", 64'(bad), 64'(0));
    force_busy[1] = 1'b0;
    @(negedge clk);
    chk(stt1 == 1'b1, "start_after_busy_drop", 64'(stt1), 64'(1));
    wait_idle(1, "backpressure");
    expect_msg(1, "backpressure", model_msg(8'h11));
    expect_empty(1, "backpressure");

    // Two requests plus a status change during byte 2: one follow-up message.
    status[1] = 8'h20;
    wait_bytes(1, 3, "req_during");
    status[1] = 8'h07;
    pulse_req(1);
    pulse_req(1);
    wait_idle(1, "req_during");
    expect_msg(1, "req_during_first", model_msg(8'h20));
    expect_msg(1, "req_during_second", model_msg(8'h07));
    expect_empty(1, "req_during");

    // Simultaneous request and status change in IDLE: a single message.
    status[1] = 8'h42;
    pulse_req(1);
    wait_idle(1, "req_and_change");
    expect_msg(1, "req_and_change", model_msg(8'h42));
    expect_empty(1, "req_and_change");

    // Reset during byte 3, stray done, then a fresh message.
    status[1] = 8'h5A;
    wait_bytes(1, 4, "reset_mid");
    rst_n = 1'b0;
    inj_done[1] = 1'b1;
    @(negedge clk);
    chk({dat1, stt1, bsy1} == 10'h0, "reset_mid_outputs", 64'({dat1, stt1, bsy1}), 64'(0));
    q1.delete();
    inj_done[1] = 1'b0;
    force_busy[1] = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    inj_done[1] = 1'b1;
    @(negedge clk);
    inj_done[1] = 1'b0;
    @(negedge clk);
    chk({dat1, stt1, bsy1} == {8'h53, 1'b0, 1'b1}, "stray_done_ignored",
        64'({dat1, stt1, bsy1}), 64'({8'h53, 1'b0, 1'b1}));
    force_busy[1] = 1'b0;
    wait_idle(1, "reset_fresh");
    expect_msg(1, "reset_fresh", 48'h533D35410D0A);
    expect_empty(1, "reset_fresh");
    expect_empty(0, "reset_r_quiet");

    // Randomized status changes on the auto instance.
    cur = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      dly[1] = int'($urandom_range(1, 12));
      s = 8'($urandom);
      if (s == cur) s = s ^ 8'h01;
      cur = s;
      status[1] = s;
      @(negedge clk);
      wait_idle(1, "rand_auto");
      expect_msg(1, "rand_auto", model_msg(s));
      expect_empty(1, "rand_auto");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
